// File: rtl/approx_mul_pkg.sv
// Shared widths and the S1 payload type for the approximate-multiplier scheduler.
// APPROX_MUL_EXACT_EN adds an exact-product flag to the payload.
package approx_mul_pkg;

  localparam int OP_W     = 8;
  localparam int RES_W    = 16;
  localparam int NIB      = 4;
  localparam int MAX_ID_W = 3;  // enough for up to 8 requesters

  typedef struct packed {
    logic [OP_W-1:0]     x;
    logic [OP_W-1:0]     y;
    logic [MAX_ID_W-1:0] id;
`ifdef APPROX_MUL_EXACT_EN
    logic                exact;
`endif
  } s1_payload_t;

  function automatic logic [RES_W-1:0] exact_mul(input logic [OP_W-1:0] x,
                                                 input logic [OP_W-1:0] y);
    return RES_W'(x) * RES_W'(y);
  endfunction

endpackage

// File: rtl/approx_mul_rr_sched_if.sv
// Request/result bundle between requesting lanes, the scheduler and the consumer.
// APPROX_MUL_EXACT_EN adds req_exact / out_exact.
interface approx_mul_rr_sched_if #(parameter int NREQ = 4);
  import approx_mul_pkg::*;

  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*OP_W-1:0] req_x;
  logic [NREQ*OP_W-1:0] req_y;
  logic                 out_valid;
  logic                 out_ready;
  logic [RES_W-1:0]     out_z;
  logic [ID_W-1:0]      out_id;
  logic                 busy;
`ifdef APPROX_MUL_EXACT_EN
  logic [NREQ-1:0]      req_exact;
  logic                 out_exact;
`endif

  modport master (
`ifdef APPROX_MUL_EXACT_EN
    output req_exact,
    input  out_exact,
`endif
    output req_valid, req_x, req_y, out_ready,
    input  req_ready, out_valid, out_z, out_id, busy
  );

  modport slave (
`ifdef APPROX_MUL_EXACT_EN
    input  req_exact,
    output out_exact,
`endif
    input  req_valid, req_x, req_y, out_ready,
    output req_ready, out_valid, out_z, out_id, busy
  );

endinterface

// File: rtl/approx_mul8_l4_core.sv
// Unsigned 8x8 approximate multiplier: exact y*x[7:4] plus a few OR-merged
// high partial products from x[3:1]; purely combinational.
module approx_mul8_l4_core
  import approx_mul_pkg::*;
(
  input  logic [OP_W-1:0]  x,
  input  logic [OP_W-1:0]  y,
  output logic [RES_W-1:0] z
);

  logic [11:0] hi_prod;
  logic        p1_7, p2_6, p3_5, p2_7, p3_6, p3_7;
  logic        unused_x0;

  assign hi_prod = 12'(y) * 12'(x[OP_W-1:NIB]);

  assign p1_7 = x[1] & y[7];
  assign p2_6 = x[2] & y[6];
  assign p3_5 = x[3] & y[5];
  assign p2_7 = x[2] & y[7];
  assign p3_6 = x[3] & y[6];
  assign p3_7 = x[3] & y[7];

  // x[0] never reaches the result in this approximation
  assign unused_x0 = x[0];

  assign z = {hi_prod, 4'b0000}
           + {7'd0, p1_7, 8'd0}
           + {7'd0, p2_6 | p3_5, 8'd0}
           + {5'd0, p2_7 | p3_6, 10'd0}
           + {5'd0, p3_7, 10'd0};

endmodule

// File: rtl/approx_mul_rr_sched.sv
// Round-robin scheduler sharing one approximate multiplier across NREQ lanes,
// with a 2-stage valid/ready pipeline. APPROX_MUL_EXACT_EN adds a per-request exact mode.
module approx_mul_rr_sched
  import approx_mul_pkg::*;
#(
  parameter int NREQ = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  approx_mul_rr_sched_if.slave bus
);

  localparam int ID_W = $clog2(NREQ);
  localparam logic [ID_W-1:0] PTR_RST = ID_W'(NREQ - 1);

  logic             s1_v;
  logic             s2_v;
  s1_payload_t      s1_q;
  s1_payload_t      s1_d;
  logic [RES_W-1:0] s2_z;
  logic [ID_W-1:0]  s2_id;
  logic [RES_W-1:0] z_approx;
  logic [RES_W-1:0] z_s1;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  cand;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_found;
  logic             s1_open;
  logic             s1_load;
  logic             s2_load;
  logic [NREQ-1:0]  ready;
`ifdef APPROX_MUL_EXACT_EN
  logic             s2_exact;
`endif

  // first valid requester strictly after the last winner
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = ptr;
    cand        = ptr;
    for (int off = 1; off <= NREQ; off++) begin
      cand = ID_W'((int'(ptr) + off) % NREQ);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign s2_load = s1_v & (!s2_v | bus.out_ready);
  assign s1_open = !s1_v | s2_load;
  assign ready   = (grant_found && s1_open && rst_n) ? (NREQ'(1) << grant_idx) : '0;
  assign s1_load = |ready;

  always_comb begin
    s1_d    = '0;
    s1_d.x  = bus.req_x[int'(grant_idx)*OP_W +: OP_W];
    s1_d.y  = bus.req_y[int'(grant_idx)*OP_W +: OP_W];
    s1_d.id = MAX_ID_W'(grant_idx);
`ifdef APPROX_MUL_EXACT_EN
    s1_d.exact = bus.req_exact[grant_idx];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= PTR_RST;
    end else if (s1_load) begin
      ptr <= grant_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_q <= '0;
    end else if (s1_load) begin
      s1_v <= 1'b1;
      s1_q <= s1_d;
    end else if (s2_load) begin
      s1_v <= 1'b0;
    end
  end

  approx_mul8_l4_core u_core (
    .x (s1_q.x),
    .y (s1_q.y),
    .z (z_approx)
  );

`ifdef APPROX_MUL_EXACT_EN
  assign z_s1 = s1_q.exact ? exact_mul(s1_q.x, s1_q.y) : z_approx;
`else
  assign z_s1 = z_approx;
`endif

  // S2 reloads on the same edge it hands off, so back-to-back results never bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v  <= 1'b0;
      s2_z  <= '0;
      s2_id <= '0;
    end else if (s2_load) begin
      s2_v  <= 1'b1;
      s2_z  <= z_s1;
      s2_id <= ID_W'(s1_q.id);
    end else if (bus.out_ready) begin
      s2_v  <= 1'b0;
    end
  end

`ifdef APPROX_MUL_EXACT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_exact <= 1'b0;
    end else if (s2_load) begin
      s2_exact <= s1_q.exact;
    end
  end

  assign bus.out_exact = s2_exact;
`endif

  assign bus.req_ready = ready;
  assign bus.out_valid = s2_v;
  assign bus.out_z     = s2_z;
  assign bus.out_id    = s2_id;
  assign bus.busy      = s1_v | s2_v;

endmodule

// File: tb/tb_approx_mul_rr_sched.sv
// Directed bench for approx_mul_rr_sched: arithmetic vectors, round-robin order,
// stall/release and mid-operation reset. Exact-mode vectors when APPROX_MUL_EXACT_EN is defined.
module tb_approx_mul_rr_sched;
  import approx_mul_pkg::*;

  localparam int NREQ = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  approx_mul_rr_sched_if #(.NREQ(NREQ)) bus ();

  approx_mul_rr_sched #(.NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [7:0] x, input logic [7:0] y);
    bus.req_x[8*id +: 8] = x;
    bus.req_y[8*id +: 8] = y;
  endtask

  task automatic single(input string tag, input int id, input logic [7:0] x,
                        input logic [7:0] y, input logic [15:0] exp);
    set_req(id, x, y);
    bus.req_valid = NREQ'(1 << id);
    #1;
    check({tag, "_ready"}, 32'(bus.req_ready), 32'(1 << id));
    step();
    bus.req_valid = '0;
    check({tag, "_s1_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_s1_busy"}, 32'(bus.busy), 1);
    step();
    check({tag, "_valid"}, 32'(bus.out_valid), 1);
    check({tag, "_z"}, 32'(bus.out_z), 32'(exp));
    check({tag, "_id"}, 32'(bus.out_id), 32'(id));
    step();
    check({tag, "_drain"}, 32'(bus.out_valid), 0);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.out_ready = 1'b1;
`ifdef APPROX_MUL_EXACT_EN
    bus.req_exact = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_z", 32'(bus.out_z), 0);
    check("rst_out_id", 32'(bus.out_id), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_req_ready", 32'(bus.req_ready), 0);
    rst_n = 1'b1;
    step();

    // arithmetic vectors; the last grant goes to 3 so the next sweep starts at 0
    single("max", 0, 8'd255, 8'd255, 16'd63760);
    single("x16y3", 1, 8'd16, 8'd3, 16'd48);
    single("x15y255", 2, 8'd15, 8'd255, 16'd2560);
    single("x0y255", 0, 8'd0, 8'd255, 16'd0);
    single("x3y200", 3, 8'd3, 8'd200, 16'd256);

    // round robin: requester i carries x=16*(i+1), y=3 -> z=48*(i+1)
    for (int i = 0; i < NREQ; i++) set_req(i, 8'(16 * (i + 1)), 8'd3);
    bus.req_valid = '1;
    #1;
    for (int k = 0; k < 8; k++) begin
      check("rr_grant", 32'(bus.req_ready), 32'(1 << (k % NREQ)));
      step();
      if (k >= 1) begin
        check("rr_valid", 32'(bus.out_valid), 1);
        check("rr_id", 32'(bus.out_id), 32'((k - 1) % NREQ));
        check("rr_z", 32'(bus.out_z), 32'(48 * ((k - 1) % NREQ + 1)));
      end
    end
    bus.req_valid = '0;
    step();
    check("rr_last_id", 32'(bus.out_id), 3);
    check("rr_last_z", 32'(bus.out_z), 192);
    step();
    check("rr_empty_valid", 32'(bus.out_valid), 0);
    check("rr_empty_busy", 32'(bus.busy), 0);

    // stall with continuous requests
    bus.out_ready = 1'b0;
    bus.req_valid = '1;
    #1;
    check("stall_grant0", 32'(bus.req_ready), 1);
    step();
    check("stall_a0_valid", 32'(bus.out_valid), 0);
    check("stall_grant1", 32'(bus.req_ready), 2);
    step();
    check("stall_full_ready", 32'(bus.req_ready), 0);
    check("stall_full_valid", 32'(bus.out_valid), 1);
    check("stall_full_z", 32'(bus.out_z), 48);
    for (int c = 0; c < 4; c++) begin
      step();
      check("stall_hold_ready", 32'(bus.req_ready), 0);
      check("stall_hold_valid", 32'(bus.out_valid), 1);
      check("stall_hold_z", 32'(bus.out_z), 48);
      check("stall_hold_id", 32'(bus.out_id), 0);
    end
    bus.out_ready = 1'b1;
    bus.req_valid = '0;
    step();
    check("release_valid", 32'(bus.out_valid), 1);
    check("release_id", 32'(bus.out_id), 1);
    check("release_z", 32'(bus.out_z), 96);
    step();
    check("release_drain", 32'(bus.out_valid), 0);
    check("release_busy", 32'(bus.busy), 0);

    // reset with both stages full; pointer sits at 1 so grants go 2 then 3
    bus.out_ready = 1'b0;
    bus.req_valid = '1;
    step();
    step();
    check("prerst_busy", 32'(bus.busy), 1);
    check("prerst_id", 32'(bus.out_id), 2);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(bus.out_valid), 0);
    check("midrst_busy", 32'(bus.busy), 0);
    check("midrst_ready", 32'(bus.req_ready), 0);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("postrst_grant", 32'(bus.req_ready), 1);
    step();
    bus.req_valid = '0;
    step();
    check("postrst_valid", 32'(bus.out_valid), 1);
    check("postrst_id", 32'(bus.out_id), 0);
    check("postrst_z", 32'(bus.out_z), 48);
    step();

`ifdef APPROX_MUL_EXACT_EN
    set_req(0, 8'd255, 8'd255);
    bus.req_exact = 4'b0001;
    bus.req_valid = 4'b0001;
    step();
    bus.req_valid = '0;
    step();
    check("exact_on_z", 32'(bus.out_z), 65025);
    check("exact_on_flag", 32'(bus.out_exact), 1);
    step();
    bus.req_exact = '0;
    bus.req_valid = 4'b0001;
    step();
    bus.req_valid = '0;
    step();
    check("exact_off_z", 32'(bus.out_z), 63760);
    check("exact_off_flag", 32'(bus.out_exact), 0);
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
